// File: rtl/icache_set_assoc.sv
`default_nettype none
// ============================================================================
// icache_set_assoc : N-way set-associative read-only L1 instruction cache.
//   Build macro ICACHE_LRU_EN selects true-LRU replacement (round-robin if not).
// Revision: 1.0
// ============================================================================
module icache_set_assoc #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int BLOCK_WORDS = 8,
  parameter  int SETS        = 128,
  parameter  int WAYS        = 2,
  localparam int LINE_W      = BLOCK_WORDS * DATA_WIDTH,
  localparam int OFFSET_W    = $clog2(LINE_W / 8),
  localparam int INDEX_W     = $clog2(SETS),
  localparam int TAG_W       = ADDR_WIDTH - INDEX_W - OFFSET_W,
  localparam int WSEL_W      = $clog2(BLOCK_WORDS)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FLUSH,
  input  logic [ADDR_WIDTH-1:0]        ADDR,
  input  logic                         ADDR_VALID,
  output logic                         CACHE_READY,
  output logic [DATA_WIDTH-1:0]        DATA,
  output logic                         DATA_VALID,
  output logic [ADDR_WIDTH-1:0]        ADDR_OUT,
  output logic                         L2_REQ_VALID,
  input  logic                         L2_REQ_READY,
  output logic [ADDR_WIDTH-OFFSET_W-1:0] L2_REQ_ADDR,
  input  logic                         L2_RESP_VALID,
  input  logic [LINE_W-1:0]            L2_RESP_DATA
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_FILL   = 2'd3
  } state_t;

  state_t                        state_q;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic                          valid_q, valid_d;
  logic                          l2_req_valid_q;
  logic [ADDR_WIDTH-OFFSET_W-1:0] l2_req_addr_q;
  logic                          discard_q;
  logic [WAY_W-1:0]              victim_q;

  logic [WAYS-1:0]   line_valid_q [SETS];
  logic [TAG_W-1:0]  tag_mem      [SETS][WAYS];
  logic [LINE_W-1:0] data_mem     [SETS][WAYS];

  logic [TAG_W-1:0]   tag_w;
  logic [INDEX_W-1:0] idx;
  logic [WSEL_W-1:0]  wsel;
  logic               match;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   repl_way;
  logic [WAY_W-1:0]   victim_d;
  logic               free_found;
  logic [WAY_W-1:0]   free_way;
  logic               fill_en;
  logic [LINE_W-1:0]  rd_line;

  assign tag_w = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign idx   = addr_q[OFFSET_W +: INDEX_W];
  assign wsel  = addr_q[OFFSET_W-1 -: WSEL_W];

  always_comb begin
    match   = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (line_valid_q[idx][w] && (tag_mem[idx][w] == tag_w)) begin
        match   = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit          = valid_q && (state_q == S_LOOKUP) && match;
  assign CACHE_READY  = (~valid_q | hit) & ~FLUSH;
  assign DATA_VALID   = hit & ~FLUSH;
  assign ADDR_OUT     = addr_q;
  assign L2_REQ_VALID = l2_req_valid_q;
  assign L2_REQ_ADDR  = l2_req_addr_q;

  // Masking with the valid bit keeps DATA X-free before the arrays are ever written.
  always_comb begin
    rd_line = '0;
    if (line_valid_q[idx][hit_way]) rd_line = data_mem[idx][hit_way];
    DATA = rd_line[wsel*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    if (CACHE_READY) begin
      addr_d  = ADDR;
      valid_d = ADDR_VALID;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!line_valid_q[idx][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
    victim_d = free_found ? free_way : repl_way;
  end

  assign fill_en = (state_q == S_WAIT) && L2_RESP_VALID && !discard_q && !FLUSH;

  always_ff @(posedge CLK) begin
    if (fill_en && !RST) begin
      tag_mem[idx][victim_q]  <= tag_w;
      data_mem[idx][victim_q] <= L2_RESP_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      for (int s = 0; s < SETS; s++) line_valid_q[s] <= '0;
    end else if (fill_en) begin
      line_valid_q[idx][victim_q] <= 1'b1;
    end
  end

  // Miss FSM; a request once raised is never withdrawn, a flush in WAIT only poisons the response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_LOOKUP;
      l2_req_valid_q <= 1'b0;
      l2_req_addr_q  <= '0;
      discard_q      <= 1'b0;
      victim_q       <= '0;
    end else begin
      case (state_q)
        S_LOOKUP: begin
          if (valid_q && !hit && !FLUSH) begin
            state_q        <= S_REQ;
            l2_req_valid_q <= 1'b1;
            l2_req_addr_q  <= addr_q[ADDR_WIDTH-1:OFFSET_W];
          end
        end
        S_REQ: begin
          if (L2_REQ_READY) begin
            state_q        <= S_WAIT;
            l2_req_valid_q <= 1'b0;
            victim_q       <= victim_d;
            discard_q      <= 1'b0;
          end
        end
        S_WAIT: begin
          if (L2_RESP_VALID) begin
            state_q   <= (discard_q || FLUSH) ? S_LOOKUP : S_FILL;
            discard_q <= 1'b0;
          end else if (FLUSH) begin
            discard_q <= 1'b1;
          end
        end
        S_FILL:  state_q <= S_LOOKUP;
        default: state_q <= S_LOOKUP;
      endcase
    end
  end

  generate
    if (WAYS == 1) begin : g_direct
      assign repl_way = '0;
    end else begin : g_repl
`ifdef ICACHE_LRU_EN
      localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);
      logic [WAY_W-1:0] age_q [SETS][WAYS];
      logic [WAY_W-1:0] max_age;
      logic             touch_en;
      logic [WAY_W-1:0] touch_way;

      assign touch_en  = fill_en | DATA_VALID;
      assign touch_way = fill_en ? victim_q : hit_way;

      always_comb begin
        repl_way = '0;
        max_age  = age_q[idx][0];
        for (int w = 1; w < WAYS; w++) begin
          if (age_q[idx][w] > max_age) begin
            max_age  = age_q[idx][w];
            repl_way = WAY_W'(w);
          end
        end
      end

      // Ways tied with the touched way also age, so the all-zero reset state settles into a permutation.
      always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
        end else if (touch_en) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way)
              age_q[idx][w] <= '0;
            else if ((age_q[idx][w] <= age_q[idx][touch_way]) && (age_q[idx][w] != AGE_MAX))
              age_q[idx][w] <= age_q[idx][w] + 1'b1;
          end
        end
      end
`else
      logic [WAY_W-1:0] rr_q [SETS];

      assign repl_way = rr_q[idx];

      always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
          for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (fill_en) begin
          rr_q[idx] <= rr_q[idx] + 1'b1;
        end
      end
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_icache_set_assoc.sv
`default_nettype none
// ============================================================================
// tb_icache_set_assoc : scoreboard bench for icache_set_assoc (default params).
// Revision: 1.0
// ============================================================================
module tb_icache_set_assoc;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int OW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FLUSH;
  logic [AW-1:0] ADDR;
  logic          ADDR_VALID;
  logic          CACHE_READY;
  logic [DW-1:0] DATA;
  logic          DATA_VALID;
  logic [AW-1:0] ADDR_OUT;
  logic          L2_REQ_VALID;
  logic          L2_REQ_READY;
  logic [AW-OW-1:0] L2_REQ_ADDR;
  logic          L2_RESP_VALID;
  logic [LW-1:0] L2_RESP_DATA;

  icache_set_assoc dut (
    .CLK           (CLK),
    .RST           (RST),
    .FLUSH         (FLUSH),
    .ADDR          (ADDR),
    .ADDR_VALID    (ADDR_VALID),
    .CACHE_READY   (CACHE_READY),
    .DATA          (DATA),
    .DATA_VALID    (DATA_VALID),
    .ADDR_OUT      (ADDR_OUT),
    .L2_REQ_VALID  (L2_REQ_VALID),
    .L2_REQ_READY  (L2_REQ_READY),
    .L2_REQ_ADDR   (L2_REQ_ADDR),
    .L2_RESP_VALID (L2_RESP_VALID),
    .L2_RESP_DATA  (L2_RESP_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   req_cycles = 0;
  int   ready_low  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // L2 backing store: every word is derived from its own address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[31:5], 2'b00, a[4:2]} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [255:0] line_data(input logic [26:0] line);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = word_at({line, 5'(i*4)});
    return d;
  endfunction

  always @(negedge CLK) begin
    if (L2_REQ_VALID) req_cycles++;
    if (!CACHE_READY) ready_low++;
    if (!RST && DATA_VALID) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_data_valid", DATA_VALID, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("addr_out", ADDR_OUT, mon_e.addr);
        check_val("data", DATA, mon_e.data);
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    int t;
    t = 0;
    @(negedge CLK);
    ADDR       = a;
    ADDR_VALID = 1'b1;
    while (!CACHE_READY && t < 40) begin
      @(negedge CLK);
      t++;
    end
    if (!CACHE_READY) check_val("fetch_accept", CACHE_READY, 1'b1);
    else              sb_q.push_back({a, word_at(a)});
  endtask

  task automatic fetch_idle();
    @(negedge CLK);
    ADDR_VALID = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check_val("drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic l2_handshake(input logic [26:0] line, input int stall);
    int t;
    t = 0;
    while (!L2_REQ_VALID && t < 40) begin
      @(negedge CLK);
      t++;
    end
    check_val("l2_req_valid", L2_REQ_VALID, 1'b1);
    check_val("l2_req_addr", L2_REQ_ADDR, line);
    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      check_val("bp_req_valid", L2_REQ_VALID, 1'b1);
      check_val("bp_req_addr", L2_REQ_ADDR, line);
      check_val("bp_cache_ready", CACHE_READY, 1'b0);
    end
    L2_REQ_READY = 1'b1;
    @(negedge CLK);
    L2_REQ_READY = 1'b0;
  endtask

  task automatic l2_respond(input logic [26:0] line, input bit bogus);
    L2_RESP_DATA  = bogus ? ~line_data(line) : line_data(line);
    L2_RESP_VALID = 1'b1;
    @(negedge CLK);
    L2_RESP_VALID = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input bit exp_hit);
    int r0;
    r0 = req_cycles;
    fetch(a);
    fetch_idle();
    if (exp_hit) begin
      wait_drain(4);
      check_val("hit_no_l2_req", req_cycles - r0, 0);
    end else begin
      l2_handshake(a[31:5], 0);
      repeat (2) @(negedge CLK);
      l2_respond(a[31:5], 1'b0);
      wait_drain(6);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, q0;
    RST = 1'b1; FLUSH = 1'b0; ADDR = '0; ADDR_VALID = 1'b0;
    L2_REQ_READY = 1'b0; L2_RESP_VALID = 1'b0; L2_RESP_DATA = '0;
    repeat (3) @(negedge CLK);
    check_val("rst_cache_ready", CACHE_READY, 1'b1);
    check_val("rst_data_valid", DATA_VALID, 1'b0);
    check_val("rst_addr_out", ADDR_OUT, 32'h0);
    check_val("rst_l2_req_valid", L2_REQ_VALID, 1'b0);
    check_val("rst_l2_req_addr", L2_REQ_ADDR, 27'h0);
    check_val("rst_data_xfree", $isunknown(DATA), 1'b0);
    RST = 1'b0;

    // Cold miss, then the whole line streamed back as hits.
    access(32'h0000_1004, 1'b0);
    r0 = req_cycles;
    q0 = ready_low;
    for (int i = 0; i < 8; i++) fetch(32'h0000_1000 + 32'(i*4));
    fetch_idle();
    wait_drain(4);
    check_val("stream_no_l2_req", req_cycles - r0, 0);
    check_val("stream_ready_drops", ready_low - q0, 0);

    // Backpressure on the L2 request.
    fetch(32'h0000_3040);
    fetch_idle();
    l2_handshake(27'h0000_0182, 5);
    l2_respond(27'h0000_0182, 1'b0);
    wait_drain(6);
    access(32'h0000_305C, 1'b1);

    // FLUSH while waiting: the response is dropped and the line re-requested.
    fetch(32'h0000_5080);
    fetch_idle();
    l2_handshake(27'h0000_0284, 0);
    FLUSH = 1'b1;
    #1;
    check_val("flush_cache_ready", CACHE_READY, 1'b0);
    @(negedge CLK);
    FLUSH = 1'b0;
    l2_respond(27'h0000_0284, 1'b1);
    check_val("flush_discard_no_dv", DATA_VALID, 1'b0);
    l2_handshake(27'h0000_0284, 0);
    l2_respond(27'h0000_0284, 1'b0);
    wait_drain(6);
    access(32'h0000_1008, 1'b0);
    access(32'h0000_3040, 1'b0);

    // Reset while waiting: late response ignored, the access misses again.
    fetch(32'h0000_70C0);
    fetch_idle();
    l2_handshake(27'h0000_0386, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sb_q.delete();
    check_val("rstw_cache_ready", CACHE_READY, 1'b1);
    check_val("rstw_l2_req_valid", L2_REQ_VALID, 1'b0);
    check_val("rstw_addr_out", ADDR_OUT, 32'h0);
    l2_respond(27'h0000_0386, 1'b0);
    check_val("rstw_late_resp_no_dv", DATA_VALID, 1'b0);
    access(32'h0000_70C0, 1'b0);

    // Three lines competing for set 0 of a 2-way cache.
    access(32'h0000_0000, 1'b0);
    access(32'h0000_1000, 1'b0);
    access(32'h0000_0004, 1'b1);
    access(32'h0000_2000, 1'b0);
`ifdef ICACHE_LRU_EN
    access(32'h0000_0008, 1'b1);
    access(32'h0000_100C, 1'b0);
`else
    access(32'h0000_100C, 1'b1);
    access(32'h0000_0008, 1'b0);
`endif

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_set_assoc.md
Name: icache_set_assoc

Overview:
- Parametrised N-way set-associative, read-only instruction cache; next generation of the team's direct-mapped L1 I-cache.
- Sits between the fetch stage and the L2 interface.
- Adds the following:
  - configurable associativity and word width;
  - a proper valid/ready L2 request handshake;
  - a miss FSM;
  - invalid-first victim selection;
  - a single-cycle FLUSH that is safe while a refill is outstanding.

Parameters:
- DATA_WIDTH, 32, fetch word width in bits (32 or 64).
- ADDR_WIDTH, 32, byte address width.
- BLOCK_WORDS, 8, words per line (power of 2, >=2).
- SETS, 128, number of sets (power of 2).
- WAYS, 2, associativity (1, 2, 4 or 8).
- Derived:
  - LINE_W = BLOCK_WORDS*DATA_WIDTH
  - OFFSET_W = clog2(LINE_W/8)
  - INDEX_W = clog2(SETS)
  - TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W
  - WSEL_W = clog2(BLOCK_WORDS)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- FLUSH  in  1  invalidate all lines
- ADDR  in  ADDR_WIDTH  fetch byte address
- ADDR_VALID  in  1  fetch request valid
- CACHE_READY  out  1  cache accepts ADDR this cycle
- DATA  out  DATA_WIDTH  fetched word for ADDR_OUT
- DATA_VALID  out  1  DATA/ADDR_OUT valid (hit)
- ADDR_OUT  out  ADDR_WIDTH  address DATA belongs to
- L2_REQ_VALID  out  1  line request to L2
- L2_REQ_READY  in  1  L2 accepts request
- L2_REQ_ADDR  out  ADDR_WIDTH-OFFSET_W  line address (tag,index)
- L2_RESP_VALID  in  1  refill line valid
- L2_RESP_DATA  in  LINE_W  refill line, word 0 at LSBs

Behaviour:
- Reset (RST, synchronous, active-high; clock CLK): all valid bits 0, replacement state 0, state=LOOKUP, addr_q=0, valid_q=0. Outputs at reset:
  - CACHE_READY=1, DATA_VALID=0, ADDR_OUT=0
  - L2_REQ_VALID=0, L2_REQ_ADDR=0
  - DATA=X-free; reads the array at index 0.
- Pipeline register: on a CLK edge with CACHE_READY=1:
  - addr_q<=ADDR and valid_q<=ADDR_VALID.
  - With CACHE_READY=0, addr_q and valid_q hold.
- Lookup (combinational on addr_q): hit = valid_q and state==LOOKUP and some way w has valid[idx][w] and tag[idx][w]==tag(addr_q). At most one way may match (fill guarantees this).
- Output signals:
  - CACHE_READY = ~valid_q | hit, and 0 in any cycle FLUSH=1.
  - DATA_VALID = hit & ~FLUSH.
  - DATA = word addr_q[OFFSET_W-1 -: WSEL_W] of the hit way.
  - ADDR_OUT = addr_q.
- Hit latency: 1 cycle (request accepted at edge N, DATA_VALID during cycle N+1). Back-to-back hits sustain 1 word/cycle.
- FSM:
  - LOOKUP: valid_q & ~hit & ~FLUSH -> REQ.
  - REQ: L2_REQ_VALID=1, L2_REQ_ADDR=addr_q[ADDR_WIDTH-1:OFFSET_W], both held stable until L2_REQ_READY is sampled high -> WAIT.
  - WAIT: on L2_RESP_VALID:
    - write line and tag into victim way;
    - set valid;
    - update replacement state;
    - -> FILL.
    - Victim is fixed when entering WAIT.
  - FILL: 1 cycle, arrays settle -> LOOKUP, where the held addr_q now hits.
  - Miss penalty: REQ handshake + L2 latency + 2 cycles.
- Victim selection: lowest-index invalid way in the set; else the replacement policy.
- FLUSH:
  - Clears every valid bit at the next edge and returns the replacement state to 0. Takes priority over a fill in the same cycle; that fill is not marked valid.
  - In REQ: L2_REQ_VALID stays asserted until handshake; no request is ever retracted.
  - In WAIT: set a discard flag; the response is consumed but not written. -> LOOKUP; addr_q re-misses and re-requests.
- L2_RESP_VALID outside WAIT is ignored.
- RST mid-operation: immediate return to reset state; any outstanding L2 response is ignored.
- WAYS=1 degenerates to direct-mapped; no replacement state.

Optional Feature:
- Macro ICACHE_LRU_EN.
- Defined:
  - true LRU per set, using a WAYS x clog2(WAYS) age matrix;
  - on hit or fill, the accessed way gets age 0 and younger ways increment;
  - victim = way with maximum age.
- Undefined: per-set round-robin pointer (clog2(WAYS) bits); victim = pointer, and the pointer increments modulo WAYS on each fill into that set. Hits do not update it.
- Interface and timing are identical in both builds.

Test Plan:
- Cold miss: RST, ADDR=0x0000_1004 valid -> L2_REQ_VALID with L2_REQ_ADDR=0x0000_0080 (32-byte lines); after response, DATA_VALID=1, DATA=word 1 of line, ADDR_OUT=0x1004.
- Hit streaming: after fill, ADDR 0x1000,0x1004,...,0x101C on consecutive cycles -> DATA_VALID every cycle, CACHE_READY never drops, no L2 request.
- Conflict, WAYS=2, SETS=128: lines 0x0000, 0x1000, 0x2000 (same set 0).
  - Sequence: fill 0x0000, fill 0x1000, touch 0x0000, fill 0x2000, then access 0x1000 and 0x0000.
  - With LRU: 0x1000 misses, 0x0000 hits.
  - Round-robin: 0x0000 misses.
- Backpressure: hold L2_REQ_READY=0 for 5 cycles -> L2_REQ_VALID and L2_REQ_ADDR stable, CACHE_READY=0 throughout.
- FLUSH in WAIT: FLUSH pulse, then L2_RESP_VALID -> line not written; same address re-requested; prior hits now miss.
- RST during WAIT: state LOOKUP, CACHE_READY=1, late L2_RESP_VALID ignored, next access misses.
